// File: rtl/mmpu_pkg.sv
// Shared encodings for the mMPU command sequencer: command type codes,
// logic function codes, request op codes and the sequencer state type.
package mmpu_pkg;

  localparam logic [1:0] TYPE_CWIN  = 2'b11;
  localparam logic [1:0] TYPE_RWIN  = 2'b10;
  localparam logic [1:0] TYPE_WR    = 2'b00;
  localparam logic [1:0] TYPE_LOGIC = 2'b01;

  localparam logic [1:0] FN_A = 2'b00;
  localparam logic [1:0] FN_B = 2'b01;
  localparam logic [1:0] FN_C = 2'b10;

  localparam logic [1:0] OP_LOGIC_A = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_LOGIC_B = 2'b10;
  localparam logic [1:0] OP_LOGIC_C = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_CWIN,
    ST_EMIT_RWIN,
    ST_EMIT_OP
  } state_t;

  // Command word is sized so a full column-window config fills it exactly.
  function automatic int cmd_w_calc(input int xb_w);
    return 2 * xb_w + 2;
  endfunction

  function automatic logic [1:0] op_to_fn(input logic [1:0] op);
    case (op)
      OP_LOGIC_B: return FN_B;
      OP_LOGIC_C: return FN_C;
      default:    return FN_A;
    endcase
  endfunction

endpackage

// File: rtl/mmpu_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle. Head word reads as zero while empty.
module mmpu_cmd_fifo #(
  parameter int CMD_W = 34,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; the empty gate on rdata hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmpu_cmd_queue.sv
// Request-to-command sequencer for the mMPU crossbar controller.
// state     | meaning
// IDLE      | waiting for a request, in_ready high
// EMIT_CWIN | pushing column-window config from the held request
// EMIT_RWIN | pushing row-window config from the held request
// EMIT_OP   | pushing the operation word, then back to IDLE
module mmpu_cmd_queue
  import mmpu_pkg::*;
#(
  parameter int DEST_W = 10,
  parameter int SRC_W  = 10,
  parameter int XB_W   = 16,
  parameter int DEPTH  = 8,
  localparam int CMD_W = cmd_w_calc(XB_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [DEST_W-1:0]    in_dest,
  input  logic [SRC_W-1:0]     in_src1,
  input  logic [SRC_W-1:0]     in_src2,
  input  logic [SRC_W-1:0]     in_rstart,
  input  logic [SRC_W-1:0]     in_rend,
  input  logic [XB_W-1:0]      in_cstart,
  input  logic [XB_W-1:0]      in_cend,
  input  logic                 in_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CMD_W-1:0]     out_cmd,
  output logic [$clog2(DEPTH):0] level,
  output logic                 busy
);

  if (CMD_W < DEST_W + 2 * SRC_W + 4) begin : g_cmd_w_check
    $error("command word too narrow for the operation encoding");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  state_t           state;
  logic [1:0]       h_op;
  logic [DEST_W-1:0] h_dest;
  logic [SRC_W-1:0] h_src1, h_src2, h_rstart, h_rend;
  logic [XB_W-1:0]  h_cstart, h_cend;
  logic             h_col;
  logic [XB_W-1:0]  cur_cstart, cur_cend;
  logic [SRC_W-1:0] cur_rstart, cur_rend;
  logic             cwin_valid, rwin_valid;

  logic             accept, pop, can_push, push;
  logic             fifo_full, fifo_empty;
  logic             cwin_hit_in, rwin_hit_in, rwin_hit_hold;
  logic [CMD_W-1:0] push_word;

  assign in_ready      = !rst && (state == ST_IDLE);
  assign accept        = in_valid && in_ready;
  assign out_valid     = !fifo_empty;
  assign pop           = out_valid && out_ready;
  assign can_push      = !fifo_full || pop;
  assign push          = (state != ST_IDLE) && can_push;
  assign busy          = (state != ST_IDLE) || (level != '0);
  assign cwin_hit_in   = cwin_valid && (in_cstart == cur_cstart) && (in_cend == cur_cend);
  assign rwin_hit_in   = rwin_valid && (in_rstart == cur_rstart) && (in_rend == cur_rend);
  assign rwin_hit_hold = rwin_valid && (h_rstart == cur_rstart) && (h_rend == cur_rend);

  // Encode the word for the current EMIT state from the held request.
  always_comb begin
    push_word = '0;
    case (state)
      ST_EMIT_CWIN: push_word = {h_cstart, h_cend, TYPE_CWIN};
      ST_EMIT_RWIN: push_word[2*SRC_W+1:0] = {h_rstart, h_rend, TYPE_RWIN};
      ST_EMIT_OP: begin
        if (h_op == OP_WRITE)
          push_word[DEST_W+2*SRC_W+1:0] = {h_dest, h_src2, h_src1, TYPE_WR};
        else
          push_word[2*SRC_W+3:0] = {op_to_fn(h_op), h_src2, h_src1, TYPE_LOGIC};
        push_word[CMD_W-1] = h_col;
      end
      default: push_word = '0;
    endcase
  end

  // Sequencer: latch request, skip unchanged windows, track window on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cwin_valid <= 1'b0;
      rwin_valid <= 1'b0;
      cur_cstart <= '0;
      cur_cend   <= '0;
      cur_rstart <= '0;
      cur_rend   <= '0;
      h_op       <= '0;
      h_dest     <= '0;
      h_src1     <= '0;
      h_src2     <= '0;
      h_rstart   <= '0;
      h_rend     <= '0;
      h_cstart   <= '0;
      h_cend     <= '0;
      h_col      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            h_op     <= in_op;
            h_dest   <= in_dest;
            h_src1   <= in_src1;
            h_src2   <= in_src2;
            h_rstart <= in_rstart;
            h_rend   <= in_rend;
            h_cstart <= in_cstart;
            h_cend   <= in_cend;
            h_col    <= in_col;
            if (!cwin_hit_in)      state <= ST_EMIT_CWIN;
            else if (!rwin_hit_in) state <= ST_EMIT_RWIN;
            else                   state <= ST_EMIT_OP;
          end
        end
        ST_EMIT_CWIN: begin
          if (can_push) begin
            cur_cstart <= h_cstart;
            cur_cend   <= h_cend;
            cwin_valid <= 1'b1;
            state      <= rwin_hit_hold ? ST_EMIT_OP : ST_EMIT_RWIN;
          end
        end
        ST_EMIT_RWIN: begin
          if (can_push) begin
            cur_rstart <= h_rstart;
            cur_rend   <= h_rend;
            rwin_valid <= 1'b1;
            state      <= ST_EMIT_OP;
          end
        end
        ST_EMIT_OP: begin
          if (can_push) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mmpu_cmd_fifo #(
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (out_cmd),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mmpu_cmd_queue.sv
// Bench for mmpu_cmd_queue: request-level reference model with an expected
// word queue, a table of window-change vectors and hand-written corner cases.
module tb_mmpu_cmd_queue;

  localparam int DEST_W = 10;
  localparam int SRC_W  = 10;
  localparam int XB_W   = 16;
  localparam int DEPTH  = 8;
  localparam int CMD_W  = 2 * XB_W + 2;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic [SRC_W-1:0]  in_src1 = '0, in_src2 = '0, in_rstart = '0, in_rend = '0;
  logic [XB_W-1:0]   in_cstart = '0, in_cend = '0;
  logic              in_col = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CMD_W-1:0]  out_cmd;
  logic [LVL_W-1:0]  level;
  logic              busy;

  always #5 clk = ~clk;

  mmpu_cmd_queue #(
    .DEST_W (DEST_W), .SRC_W (SRC_W), .XB_W (XB_W), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_op (in_op),
    .in_dest (in_dest), .in_src1 (in_src1), .in_src2 (in_src2),
    .in_rstart (in_rstart), .in_rend (in_rend),
    .in_cstart (in_cstart), .in_cend (in_cend), .in_col (in_col),
    .out_valid (out_valid), .out_ready (out_ready), .out_cmd (out_cmd),
    .level (level), .busy (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  typedef struct {
    logic [1:0] op;
    int dest, src1, src2, rs, re, cs, ce;
    bit col;
  } req_t;

  // Reference model: which words a request produces, kept at word level.
  longint exp_q[$];
  bit     m_cv = 0, m_rv = 0;
  int     m_cs, m_ce, m_rs, m_re;
  int     max_level = 0;
  int     pop_count = 0;

  function automatic longint op_word(input req_t r);
    longint w;
    longint fn;
    if (r.op == 2'b01) begin
      w = 0 + longint'(r.src1) * 4 + longint'(r.src2) * 4096 + longint'(r.dest) * 4194304;
    end else begin
      fn = (r.op == 2'b00) ? 0 : (r.op == 2'b10) ? 1 : 2;
      w = 1 + longint'(r.src1) * 4 + longint'(r.src2) * 4096 + fn * 4194304;
    end
    if (r.col) w = w + (longint'(1) << (CMD_W - 1));
    return w;
  endfunction

  function automatic void model_accept(input req_t r);
    if (!m_cv || r.cs != m_cs || r.ce != m_ce) begin
      exp_q.push_back(3 + longint'(r.ce) * 4 + longint'(r.cs) * 262144);
      m_cv = 1; m_cs = r.cs; m_ce = r.ce;
    end
    if (!m_rv || r.rs != m_rs || r.re != m_re) begin
      exp_q.push_back(2 + longint'(r.re) * 4 + longint'(r.rs) * 4096);
      m_rv = 1; m_rs = r.rs; m_re = r.re;
    end
    exp_q.push_back(op_word(r));
  endfunction

  function automatic req_t cur_req();
    req_t r;
    r.op = in_op; r.dest = int'(in_dest); r.src1 = int'(in_src1); r.src2 = int'(in_src2);
    r.rs = int'(in_rstart); r.re = int'(in_rend); r.cs = int'(in_cstart); r.ce = int'(in_cend);
    r.col = in_col;
    return r;
  endfunction

  // Handshakes seen at the negedge complete at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cv = 0;
      m_rv = 0;
    end else begin
      if (out_valid && out_ready) begin
        pop_count++;
        if (exp_q.size() == 0) fail_msg("pop_unexpected");
        else begin
          chk("pop_word", longint'(out_cmd), exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept(cur_req());
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input req_t r);
    int n = 0;
    in_op = r.op; in_dest = DEST_W'(r.dest); in_src1 = SRC_W'(r.src1); in_src2 = SRC_W'(r.src2);
    in_rstart = SRC_W'(r.rs); in_rend = SRC_W'(r.re);
    in_cstart = XB_W'(r.cs); in_cend = XB_W'(r.ce); in_col = r.col;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin step(); n++; end
    if (!in_ready) fail_msg("accept_timeout");
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin step(); n++; end
    if (!in_ready) fail_msg("idle_timeout");
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((level != 0 || !in_ready) && n < 300) begin step(); n++; end
    if (level != 0 || !in_ready) fail_msg("drain_timeout");
    out_ready = 1'b0;
    chk("model_empty", exp_q.size(), 0);
  endtask

  function automatic req_t mk(input logic [1:0] op, input int dest, input int s1, input int s2,
                              input int rs, input int re, input int cs, input int ce, input bit col);
    req_t r;
    r.op = op; r.dest = dest; r.src1 = s1; r.src2 = s2;
    r.rs = rs; r.re = re; r.cs = cs; r.ce = ce; r.col = col;
    return r;
  endfunction

  typedef struct {
    req_t req;
    int   exp_words;
    int   exp_type;
  } vec_t;

  vec_t   vecs[8];
  req_t   r;
  bit     rnd_done;
  int     pops_before;

  initial begin
    // Table: window tracking entering here is rows 0..9, cols 0..15.
    vecs[0] = '{mk(2'b01, 7, 3, 4, 0, 9, 0, 15, 0), 1, 0};
    vecs[1] = '{mk(2'b10, 0, 5, 6, 0, 9, 3, 15, 0), 2, 3};
    vecs[2] = '{mk(2'b00, 0, 8, 9, 2, 9, 3, 15, 0), 2, 2};
    vecs[3] = '{mk(2'b11, 0, 1, 1, 4, 5, 100, 200, 0), 3, 3};
    vecs[4] = '{mk(2'b01, 1023, 1023, 0, 4, 5, 100, 200, 1), 1, 0};
    vecs[5] = '{mk(2'b10, 0, 12, 34, 4, 5, 100, 200, 1), 1, 1};
    vecs[6] = '{mk(2'b00, 0, 2, 3, 4, 6, 0, 0, 0), 3, 3};
    vecs[7] = '{mk(2'b11, 0, 7, 8, 4, 6, 0, 0, 1), 1, 1};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_cmd", longint'(out_cmd), 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // First request: CWIN, RWIN, WRITE
    out_ready = 1'b0;
    send(mk(2'b01, 5, 1, 2, 0, 7, 0, 15, 0));
    chk("first_in_ready_low", in_ready, 0);
    chk("first_level_t0", level, 0);
    step();
    chk("first_level_t1", level, 1);
    chk("first_out_valid", out_valid, 1);
    chk("first_cwin_word", longint'(out_cmd), 63);
    step();
    chk("first_level_t2", level, 2);
    step();
    chk("first_level_t3", level, 3);
    chk("first_in_ready_back", in_ready, 1);
    drain();

    // Same windows: one LOGIC fn=00 word, in_ready low for one cycle
    send(mk(2'b00, 0, 1, 2, 0, 7, 0, 15, 0));
    chk("same_in_ready_low", in_ready, 0);
    step();
    chk("same_in_ready_high", in_ready, 1);
    chk("same_level", level, 1);
    chk("same_logic_word", longint'(out_cmd), 8197);
    drain();

    // Only rend changes: RWIN then LOGIC fn=10, no CWIN
    send(mk(2'b11, 0, 1, 2, 0, 9, 0, 15, 0));
    step();
    chk("row_first_word", longint'(out_cmd), 38);
    chk("row_level1", level, 1);
    chk("row_in_ready_low", in_ready, 0);
    step();
    chk("row_level2", level, 2);
    chk("row_in_ready_high", in_ready, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("row_level_after_pop", level, 1);
    chk("row_op_word", longint'(out_cmd), 8396805);
    drain();

    // Table-driven window change vectors
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].req);
      wait_idle();
      chk($sformatf("vec%0d_words", i), level, vecs[i].exp_words);
      chk($sformatf("vec%0d_type", i), out_cmd[1:0], vecs[i].exp_type);
      drain();
    end

    // Fill to DEPTH, stall in EMIT_OP, then one pop lets the push land
    for (int i = 0; i < DEPTH; i++)
      send(mk(2'b10, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 4, 6, 0, 0, 0));
    wait_idle();
    chk("full_level", level, DEPTH);
    send(mk(2'b01, 77, 11, 22, 4, 6, 0, 0, 1));
    repeat (3) step();
    chk("stall_level", level, DEPTH);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pushpop_level", level, DEPTH);
    chk("pushpop_in_ready", in_ready, 1);
    drain();

    // Pointer wrap: 20 single-word requests with continuous drain
    max_level = 0;
    pops_before = pop_count;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send(mk(2'($urandom_range(0, 3)), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), 4, 6, 0, 0, 1'($urandom_range(0, 1))));
    drain();
    chk("wrap_max_level_le2", (max_level <= 2), 1);
    chk("wrap_pops", pop_count - pops_before, 20);

    // Random requests with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(mk(2'($urandom_range(0, 3)), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023),
                  ($urandom_range(0, 1) != 0) ? 3 : 0, ($urandom_range(0, 1) != 0) ? 9 : 7,
                  ($urandom_range(0, 1) != 0) ? 8 : 0, ($urandom_range(0, 1) != 0) ? 31 : 15,
                  1'($urandom_range(0, 1))));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    chk("rnd_max_level_le_depth", (max_level <= DEPTH), 1);

    // Reset while in EMIT_RWIN with 4 words queued
    send(mk(2'b01, 1, 2, 3, 1, 2, 5, 6, 0));
    send(mk(2'b00, 0, 4, 5, 1, 2, 5, 6, 0));
    wait_idle();
    chk("pre_rst_level", level, 4);
    send(mk(2'b10, 0, 6, 7, 1, 3, 5, 6, 0));
    chk("pre_rst_in_ready", in_ready, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    step();
    send(mk(2'b10, 0, 6, 7, 1, 3, 5, 6, 0));
    step();
    chk("post_rst_first_type", out_cmd[1:0], 3);
    wait_idle();
    chk("post_rst_words", level, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
